spi_mem_responder: RTL and testbench

SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

---
 rtl/spi_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_responder
// Description : SPI mode-0 responder with a DEPTH x 8 register file that
//               supports read (0x03) and write (0x02) commands. Define
//               SPI_RESP_STATUS_EN to enable the status command (0x05).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_responder #(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic miso,
   output logic miso_oe
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR    = 3'd2,
      RD_DATA = 3'd3,
      WR_DATA = 3'd4,
      STATUS  = 3'd5,
      IGNORE  = 3'd6
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic          r_cs_meta, r_cs_sync, r_cs_prev;
   logic          r_mosi_meta, r_mosi_sync;

   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_sh_in;
   logic [7:0]    r_sh_out;
   logic          r_miso;
   logic          r_is_read;
   logic [AW-1:0] r_ptr;
   logic [7:0]    r_mem [DEPTH];

   logic          w_rise;
   logic          w_fall;
   logic          w_cs_fall;
   logic          w_byte_done;
   logic [7:0]    w_byte;
   logic [7:0]    w_load_byte;
   logic [7:0]    w_status_byte;

   assign w_rise      = r_sclk_sync & ~r_sclk_prev;
   assign w_fall      = ~r_sclk_sync & r_sclk_prev;
   assign w_cs_fall   = r_cs_prev & ~r_cs_sync;
   assign w_byte      = {r_sh_in[6:0], r_mosi_sync};
   assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);

`ifdef SPI_RESP_STATUS_EN
   logic [4:0] r_wr_cnt;
   assign w_status_byte = {3'b000, r_wr_cnt};
`else
   assign w_status_byte = 8'h00;
`endif

   assign w_load_byte = (r_state == STATUS) ? w_status_byte : r_mem[r_ptr];

   assign miso_oe = ((r_state == RD_DATA) || (r_state == STATUS)) && !r_cs_sync;
   assign miso    = r_miso & miso_oe;

   always_comb begin
      w_state_nxt = r_state;
      if ((r_state != IDLE) && r_cs_sync) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: if (w_cs_fall) w_state_nxt = CMD;
            CMD: begin
               if (w_byte_done) begin
                  case (w_byte)
                     8'h03, 8'h02: w_state_nxt = ADDR;
`ifdef SPI_RESP_STATUS_EN
                     8'h05:        w_state_nxt = STATUS;
`endif
                     default:      w_state_nxt = IGNORE;
                  endcase
               end
            end
            ADDR: if (w_byte_done) w_state_nxt = r_is_read ? RD_DATA : WR_DATA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sclk_meta <= 1'b0;
         r_sclk_sync <= 1'b0;
         r_sclk_prev <= 1'b0;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_cs_prev   <= 1'b1;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
         r_state     <= IDLE;
         r_bit_cnt   <= 3'd0;
         r_sh_in     <= 8'h00;
         r_sh_out    <= 8'h00;
         r_miso      <= 1'b0;
         r_is_read   <= 1'b0;
         r_ptr       <= '0;
`ifdef SPI_RESP_STATUS_EN
         r_wr_cnt    <= 5'd0;
`endif
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      end else begin
         r_sclk_meta <= sclk;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_cs_meta   <= cs_n;
         r_cs_sync   <= r_cs_meta;
         r_cs_prev   <= r_cs_sync;
         r_mosi_meta <= mosi;
         r_mosi_sync <= r_mosi_meta;
         r_state     <= w_state_nxt;

         if ((r_state == IDLE) || (w_state_nxt == IDLE)) r_bit_cnt <= 3'd0;
         else if (w_rise)                                  r_bit_cnt <= r_bit_cnt + 3'd1;

         if (w_rise) r_sh_in <= w_byte;

         case (r_state)
            CMD: begin
               if (w_byte_done) begin
                  r_is_read <= (w_byte == 8'h03);
`ifdef SPI_RESP_STATUS_EN
                  if (w_byte == 8'h05) begin
                     r_sh_out <= w_status_byte;
                     r_miso   <= w_status_byte[7];
                  end
`endif
               end
            end
            ADDR: begin
               if (w_byte_done) begin
                  r_ptr <= w_byte[AW-1:0];
                  if (r_is_read) begin
                     r_sh_out <= r_mem[w_byte[AW-1:0]];
                     r_miso   <= r_mem[w_byte[AW-1:0]][7];
                  end
               end
            end
            RD_DATA, STATUS: begin
               if (w_byte_done && (r_state == RD_DATA)) r_ptr <= r_ptr + AW'(1);
               // Counter at 0 on a fall means a byte boundary: reload (the first
               // such fall harmlessly reloads the byte already presented).
               if (w_fall) begin
                  if (r_bit_cnt == 3'd0) begin
                     r_sh_out <= w_load_byte;
                     r_miso   <= w_load_byte[7];
                  end else begin
                     r_sh_out <= {r_sh_out[6:0], 1'b0};
                     r_miso   <= r_sh_out[6];
                  end
               end
            end
            WR_DATA: begin
               if (w_byte_done) begin
                  r_mem[r_ptr] <= w_byte;
                  r_ptr        <= r_ptr + AW'(1);
`ifdef SPI_RESP_STATUS_EN
                  if (r_wr_cnt != 5'd31) r_wr_cnt <= r_wr_cnt + 5'd1;
`endif
               end
            end
            default: ;
         endcase

         if (w_state_nxt == IDLE) r_miso <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_mem_responder
// Description : Self-checking bench: table-driven read/write transactions
//               plus abort, unknown-command, status and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_responder;

   logic clk = 1'b0;
   logic rst, sclk, cs_n, mosi;
   logic miso, miso_oe;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_count = 0;

   logic [7:0] exp_q [$];
   logic [7:0] tx_q  [$];

   typedef struct {
      bit          rd;
      logic [7:0]  addr;
      int          n;
      logic [31:0] d;
   } vec_t;

   vec_t vecs [6];

   spi_mem_responder #(.DEPTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .sclk    (sclk),
      .cs_n    (cs_n),
      .mosi    (mosi),
      .miso    (miso),
      .miso_oe (miso_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One SPI bit is 80 ns (8 clk); miso is sampled just before each rise.
   task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit cs_last,
                           output logic [7:0] rx, output int oe_cnt);
      rx = 8'h00;
      oe_cnt = 0;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         #40;
         rx = {rx[6:0], miso};
         oe_cnt += int'(miso_oe);
         sclk = 1'b1;
         if (cs_last && (i == nbits - 1)) cs_n = 1'b1;
         #40;
         sclk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      #40;
   endtask

   task automatic cs_end();
      #40;
      cs_n = 1'b1;
      #80;
      check("oe_idle", {31'd0, miso_oe}, 32'd0);
      check("miso_idle", {31'd0, miso}, 32'd0);
   endtask

   task automatic do_write(input logic [7:0] addr, input int n);
      logic [7:0] rx;
      int oe;
      cs_begin();
      spi_bits(8'h02, 8, 1'b0, rx, oe);
      spi_bits(addr, 8, 1'b0, rx, oe);
      check("wr_addr_oe", oe, 0);
      for (int i = 0; i < n; i++) begin
         spi_bits(tx_q.pop_front(), 8, 1'b0, rx, oe);
         check("wr_data_oe", oe, 0);
         wr_count++;
      end
      cs_end();
   endtask

   task automatic do_read(input logic [7:0] addr, input int n);
      logic [7:0] rx;
      int oe;
      cs_begin();
      spi_bits(8'h03, 8, 1'b0, rx, oe);
      check("rd_cmd_oe", oe, 0);
      spi_bits(addr, 8, 1'b0, rx, oe);
      check("rd_addr_oe", oe, 0);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'h00, 8, 1'b0, rx, oe);
         if (exp_q.size() == 0) check("rd_queue_empty", 1, 0);
         else                   check("rd_data", rx, exp_q.pop_front());
         check("rd_data_oe", oe, 8);
      end
      cs_end();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] rx;
      int oe;
      logic [31:0] st_exp;

      vecs[0] = '{1'b0, 8'h04, 2, 32'hA53C_0000};
      vecs[1] = '{1'b1, 8'h04, 2, 32'hA53C_0000};
      vecs[2] = '{1'b0, 8'h0F, 2, 32'h1122_0000};
      vecs[3] = '{1'b1, 8'h0F, 2, 32'h1122_0000};
      vecs[4] = '{1'b1, 8'h14, 2, 32'hA53C_0000};
      vecs[5] = '{1'b1, 8'h0E, 4, 32'h0011_2200};

      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      #32;
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_oe", {31'd0, miso_oe}, 32'd0);
      rst = 1'b0;
      #20;

      for (int v = 0; v < 6; v++) begin
         for (int b = 0; b < vecs[v].n; b++) begin
            if (vecs[v].rd) exp_q.push_back(vecs[v].d[31-8*b -: 8]);
            else            tx_q.push_back(vecs[v].d[31-8*b -: 8]);
         end
         if (vecs[v].rd) do_read(vecs[v].addr, vecs[v].n);
         else            do_write(vecs[v].addr, vecs[v].n);
      end

      // Abort: partial byte must not reach storage
      tx_q.push_back(8'h5A);
      do_write(8'h01, 1);
      cs_begin();
      spi_bits(8'h02, 8, 1'b0, rx, oe);
      spi_bits(8'h01, 8, 1'b0, rx, oe);
      spi_bits(8'hFF, 5, 1'b0, rx, oe);
      cs_end();
      exp_q.push_back(8'h5A);
      do_read(8'h01, 1);

      // Byte completing on the same clk as cs_n deassert is committed
      cs_begin();
      spi_bits(8'h02, 8, 1'b0, rx, oe);
      spi_bits(8'h07, 8, 1'b0, rx, oe);
      spi_bits(8'hC3, 8, 1'b1, rx, oe);
      wr_count++;
      #120;
      exp_q.push_back(8'hC3);
      do_read(8'h07, 1);

      // Unrecognized command: no drive, storage untouched
      cs_begin();
      spi_bits(8'h9F, 8, 1'b0, rx, oe);
      spi_bits(8'h04, 8, 1'b0, rx, oe);
      check("unk_oe0", oe, 0);
      spi_bits(8'hFF, 8, 1'b0, rx, oe);
      check("unk_oe1", oe, 0);
      check("unk_miso", rx, 0);
      cs_end();
      exp_q.push_back(8'hA5);
      do_read(8'h04, 1);

      // Status command
      st_exp = (wr_count > 31) ? 32'd31 : 32'(wr_count);
      cs_begin();
      spi_bits(8'h05, 8, 1'b0, rx, oe);
      for (int i = 0; i < 2; i++) begin
         spi_bits(8'h00, 8, 1'b0, rx, oe);
`ifdef SPI_RESP_STATUS_EN
         check("status_byte", rx, st_exp);
         check("status_oe", oe, 8);
`else
         check("status_off_byte", rx, 0);
         check("status_off_oe", oe, 0);
`endif
      end
      cs_end();

      // Reset during the 4th data bit of a read
      cs_begin();
      spi_bits(8'h03, 8, 1'b0, rx, oe);
      spi_bits(8'h04, 8, 1'b0, rx, oe);
      spi_bits(8'h00, 3, 1'b0, rx, oe);
      #20;
      rst = 1'b1;
      #10;
      check("rstmid_miso", {31'd0, miso}, 32'd0);
      check("rstmid_oe", {31'd0, miso_oe}, 32'd0);
      #10;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
      cs_n = 1'b1;
      #40;
      rst = 1'b0;
      #80;
      for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
      do_read(8'h00, 16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
